ifu_fetch_ctrl: RTL and testbench
=================================

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset, SHALL be provided.
REQ-002 Parameter TIMEOUT, 16, maximum cycles waiting for a memory response before error, SHALL be provided; legal range 2..255.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_req_valid  out  1  fetch request to instruction memory.
REQ-006 mem_req_ready  in  1  memory accepts request.
REQ-007 mem_req_addr  out  32  word-aligned fetch address.
REQ-008 mem_rsp_valid  in  1  response data valid; at most one per accepted request.
REQ-009 mem_rsp_data  in  32  fetched instruction word.
REQ-010 inst_valid  out  1  instruction available to decode.
REQ-011 inst_ready  in  1  decode accepts instruction.
REQ-012 inst_data  out  32  held instruction word.
REQ-013 inst_pc  out  32  address of inst_data.
REQ-014 redirect_valid  in  1  one-cycle control-flow change from execute.
REQ-015 redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0.
REQ-016 fetch_err  out  1  sticky timeout error.

Function
REQ-017 The block SHALL implement states IDLE, REQ, WAIT, HOLD, ERR and SHALL allow at most one outstanding memory request.
REQ-018 IDLE: SHALL move to REQ on the first clock edge after reset release.
REQ-019 REQ: mem_req_valid=1, mem_req_addr=pc; on mem_req_valid&&mem_req_ready SHALL go to WAIT and clear the timeout counter.
REQ-020 WAIT: on mem_rsp_valid SHALL capture mem_rsp_data into inst_data and pc into inst_pc, then go to HOLD; response-to-inst_valid latency is one cycle.
REQ-021 HOLD: inst_valid=1 with inst_data/inst_pc stable; on inst_ready SHALL set pc=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and go to REQ.
REQ-022 Redirect in REQ without handshake SHALL load pc and stay in REQ; mem_req_addr shows the new pc next cycle.
REQ-023 Redirect in the same cycle as a REQ handshake, or in WAIT, SHALL load pc and set a drop flag; the next response SHALL be discarded (no HOLD) and the FSM SHALL return to REQ.
REQ-024 Redirect in HOLD SHALL discard the held instruction, load pc and go to REQ; if inst_ready is also high, the transfer counts as completed and pc SHALL take redirect_pc, not pc+4.
REQ-025 Redirect and mem_rsp_valid in the same WAIT cycle: the response SHALL be discarded, pc loaded, FSM to REQ.
REQ-026 Timeout counter SHALL increment each WAIT cycle without response; reaching TIMEOUT SHALL enter ERR.
REQ-027 ERR: fetch_err=1, mem_req_valid=0, inst_valid=0; redirects ignored; exit only by reset.
REQ-028 mem_req_valid SHALL NOT drop in REQ until the handshake completes or ERR is entered.

Reset
REQ-029 Reset assertion SHALL force, asynchronously: state IDLE, pc=RESET_PC, drop flag 0, counter 0, mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_err=0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the outstanding request; the memory side is reset by the same rst_n.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/REQ/WAIT/HOLD/ERR), RESET_PC default and the instruction width constant 32.
REQ-032 The block SHALL be one module; the optional sub-module ifu_pc_reg (pc register with increment/redirect mux) is natural.

Verification
REQ-033 Reset release, mem ready=1, rsp 1 cycle later, inst_ready=1 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 fetched in order with matching inst_pc.
REQ-034 inst_ready low 5 cycles in HOLD -> inst_valid held, inst_data/inst_pc unchanged, no new mem request.
REQ-035 Redirect to 0x8000_0103 in WAIT -> response discarded, next mem_req_addr=0x8000_0100, no inst_valid for stale word.
REQ-036 Redirect 0x8000_0040 with inst_ready in HOLD -> next fetch 0x8000_0040, not pc+4.
REQ-037 mem_rsp_valid never asserted -> fetch_err=1 after 16 WAIT cycles, all valids 0, stays until rst_n low.
REQ-038 rst_n low mid-WAIT then released -> fetch restarts at 0x8000_0000, late response ignored.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifu_fetch_ctrl_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_pc_reg.sv
// Fetch PC register: redirect load has priority over sequential increment.
module ifu_fetch_ctrl_pc_reg
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        incr,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  always_comb begin
    if (load) begin
      pc_next = word_align(load_pc);
    end else if (incr) begin
      pc_next = pc + 32'd4;
    end else begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, redirect handling,
// response drop after redirect and sticky timeout error.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  fetch_state_e      state, state_next;
  logic [7:0]        cnt, cnt_next;
  logic              drop, drop_next;
  logic [31:0]       pc;
  logic [INST_W-1:0] data_q;
  logic [31:0]       pc_q;
  logic              handshake, redirect_act, timeout, capture, pc_incr;

  assign handshake    = (state == REQ) && mem_req_ready;
  assign redirect_act = redirect_valid &&
                        ((state == REQ) || (state == WAIT) || (state == HOLD));
  assign timeout      = (state == WAIT) && !mem_rsp_valid && ((cnt + 8'd1) == TIMEOUT_C);
  // A response is kept only if no redirect is pending or arriving with it.
  assign capture      = (state == WAIT) && mem_rsp_valid && !drop && !redirect_valid;
  assign pc_incr      = (state == HOLD) && inst_ready;

  ifu_fetch_ctrl_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect_act),
    .incr    (pc_incr),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      drop   <= 1'b0;
      data_q <= '0;
      pc_q   <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      drop  <= drop_next;
      if (capture) begin
        data_q <= mem_rsp_data;
        pc_q   <= pc;
      end else begin
        data_q <= data_q;
        pc_q   <= pc_q;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ:  state_next = handshake ? WAIT : REQ;
      WAIT: begin
        if (mem_rsp_valid) begin
          state_next = (drop || redirect_valid) ? REQ : HOLD;
        end else if (timeout) begin
          state_next = ERR;
        end else begin
          state_next = WAIT;
        end
      end
      HOLD:    state_next = (redirect_valid || inst_ready) ? REQ : HOLD;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Drop flag marks the in-flight response as stale after a redirect.
  always_comb begin
    cnt_next  = cnt;
    drop_next = drop;
    if (handshake) begin
      cnt_next  = 8'd0;
      drop_next = redirect_valid;
    end else if (state == WAIT) begin
      if (mem_rsp_valid) begin
        drop_next = 1'b0;
      end else begin
        cnt_next  = cnt + 8'd1;
        drop_next = drop || redirect_valid;
      end
    end else begin
      cnt_next  = cnt;
      drop_next = drop;
    end
  end

  always_comb begin
    mem_req_valid = (state == REQ);
    mem_req_addr  = pc;
    inst_valid    = (state == HOLD);
    inst_data     = data_q;
    inst_pc       = pc_q;
    fetch_err     = (state == ERR);
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: cycle table plus timeout and reset sequences.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        ird;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] id;
    logic [31:0] ipc;
    logic        err;
  } vec_t;

  localparam int NVEC = 35;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic rdy, logic rspv, logic [31:0] rspd, logic ird,
                              logic redir, logic [31:0] rpc, logic req, logic [31:0] addr,
                              logic iv, logic [31:0] id, logic [31:0] ipc, logic err);
    vec_t v;
    v.rdy = rdy;   v.rspv = rspv; v.rspd = rspd; v.ird = ird;
    v.redir = redir; v.rpc = rpc; v.req = req;   v.addr = addr;
    v.iv = iv;     v.id = id;     v.ipc = ipc;   v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic ird, input logic redir, input logic [31:0] rpc);
    mem_req_ready  = rdy;
    mem_rsp_valid  = rspv;
    mem_rsp_data   = rspd;
    inst_ready     = ird;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  // Address is only meaningful while requesting, held data only while valid.
  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic iv, input logic [31:0] id, input logic [31:0] ipc,
                         input logic err);
    chk({tag, ".req_valid"}, {31'd0, mem_req_valid}, {31'd0, req});
    if (req) chk({tag, ".req_addr"}, mem_req_addr, addr);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, iv});
    if (iv) begin
      chk({tag, ".inst_data"}, inst_data, id);
      chk({tag, ".inst_pc"}, inst_pc, ipc);
    end
    chk({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0,0,32'h0,0,0,32'h0,          0,32'h0,0,32'h0,32'h0,0);
    vecs[1]  = mk(1,0,32'h0,0,0,32'h0,          1,32'h8000_0000,0,32'h0,32'h0,0);
    vecs[2]  = mk(0,1,32'hAAAA_0000,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    vecs[3]  = mk(0,0,32'h0,1,0,32'h0,          0,32'h0,1,32'hAAAA_0000,32'h8000_0000,0);
    vecs[4]  = mk(1,0,32'h0,0,0,32'h0,          1,32'h8000_0004,0,32'h0,32'h0,0);
    vecs[5]  = mk(0,1,32'hBBBB_0004,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    vecs[6]  = mk(0,0,32'h0,1,0,32'h0,          0,32'h0,1,32'hBBBB_0004,32'h8000_0004,0);
    vecs[7]  = mk(0,0,32'h0,0,0,32'h0,          1,32'h8000_0008,0,32'h0,32'h0,0);
    vecs[8]  = mk(1,0,32'h0,0,0,32'h0,          1,32'h8000_0008,0,32'h0,32'h0,0);
    vecs[9]  = mk(0,1,32'hCCCC_0008,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    for (int i = 10; i < 15; i++)
      vecs[i] = mk(0,0,32'h0,0,0,32'h0,         0,32'h0,1,32'hCCCC_0008,32'h8000_0008,0);
    vecs[15] = mk(0,0,32'h0,1,0,32'h0,          0,32'h0,1,32'hCCCC_0008,32'h8000_0008,0);
    vecs[16] = mk(1,0,32'h0,0,0,32'h0,          1,32'h8000_000C,0,32'h0,32'h0,0);
    vecs[17] = mk(0,0,32'h0,0,1,32'h8000_0103,  0,32'h0,0,32'h0,32'h0,0);
    vecs[18] = mk(0,1,32'hDEAD_BEEF,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    vecs[19] = mk(1,0,32'h0,0,0,32'h0,          1,32'h8000_0100,0,32'h0,32'h0,0);
    vecs[20] = mk(0,1,32'h1234_0100,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    vecs[21] = mk(0,0,32'h0,1,1,32'h8000_0040,  0,32'h0,1,32'h1234_0100,32'h8000_0100,0);
    vecs[22] = mk(0,0,32'h0,0,1,32'h8000_0200,  1,32'h8000_0040,0,32'h0,32'h0,0);
    vecs[23] = mk(1,0,32'h0,0,1,32'h8000_0300,  1,32'h8000_0200,0,32'h0,32'h0,0);
    vecs[24] = mk(0,1,32'h5555_5555,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    vecs[25] = mk(1,0,32'h0,0,0,32'h0,          1,32'h8000_0300,0,32'h0,32'h0,0);
    vecs[26] = mk(0,1,32'hBAD0_0300,0,1,32'h8000_0400, 0,32'h0,0,32'h0,32'h0,0);
    vecs[27] = mk(1,0,32'h0,0,0,32'h0,          1,32'h8000_0400,0,32'h0,32'h0,0);
    vecs[28] = mk(0,1,32'h6666_0400,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    vecs[29] = mk(0,0,32'h0,1,0,32'h0,          0,32'h0,1,32'h6666_0400,32'h8000_0400,0);
    vecs[30] = mk(0,0,32'h0,0,1,32'hFFFF_FFFF,  1,32'h8000_0404,0,32'h0,32'h0,0);
    vecs[31] = mk(1,0,32'h0,0,0,32'h0,          1,32'hFFFF_FFFC,0,32'h0,32'h0,0);
    vecs[32] = mk(0,1,32'h7777_FFFC,0,0,32'h0,  0,32'h0,0,32'h0,32'h0,0);
    vecs[33] = mk(0,0,32'h0,1,0,32'h0,          0,32'h0,1,32'h7777_FFFC,32'hFFFF_FFFC,0);
    vecs[34] = mk(1,0,32'h0,0,0,32'h0,          1,32'h0000_0000,0,32'h0,32'h0,0);

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset.inst_data", inst_data, 32'h0);
    chk("reset.inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) @(negedge clk);
      chk_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].iv,
              vecs[i].id, vecs[i].ipc, vecs[i].err);
      drive(vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].ird, vecs[i].redir, vecs[i].rpc);
    end

    // Timeout: handshake at the last vector, then 16 silent WAIT cycles.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk_out($sformatf("wait%0d", k), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_out($sformatf("err%0d", k), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      drive(1, 1, 32'h4444_0000, 1, 1, 32'h8000_0800);
    end

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("arst.inst_data", inst_data, 32'h0);
    chk("arst.inst_pc", inst_pc, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_out("r1.idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk_out("r1.req", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk_out("r1.wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 1, 32'hDEAD_0000, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_out("r2.idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(0, 1, 32'hDEAD_0000, 0, 0, 32'h0);
    @(negedge clk);
    chk_out("r2.req", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk_out("r2.wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(0, 1, 32'h9999_0000, 0, 0, 32'h0);
    @(negedge clk);
    chk_out("r2.hold", 1'b0, 32'h0, 1'b1, 32'h9999_0000, 32'h8000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
